// File: rtl/fifo_stream_reader.sv
// Read-side burst controller: drains `len` words from a synchronous FIFO into a valid/ready stream.
// Optional FIFO_RD_CNT_EN adds a free-running 16-bit stream transfer counter output xfer_cnt.
module fifo_stream_reader #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]       xfer_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q, issued, delivered;
   logic [1:0]        occ;
   logic              inflight, head, pop, accept;
   logic [2:0]        pending;
   logic [DATA_W-1:0] buf_mem [2];

   assign m_valid = (occ != 2'd0);
   assign m_data  = buf_mem[head];
   assign pop     = m_valid && m_ready;
   assign pending = {1'b0, occ} + {2'b0, inflight};

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      fifo_rd_en = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = (len != '0);
               state_nxt = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            // occ + inflight - pop < 2, rearranged to stay unsigned
            fifo_rd_en = rst && !fifo_empty && (issued != len_q) &&
                         (pending < (3'd2 + {2'b0, pop}));
            if ((issued + LEN_W'(fifo_rd_en)) == len_q) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if ((delivered + LEN_W'(pop)) == len_q) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q      <= '0;
         issued     <= '0;
         delivered  <= '0;
         occ        <= '0;
         inflight   <= 1'b0;
         head       <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (accept) begin
            len_q     <= len;
            issued    <= '0;
            delivered <= '0;
         end else begin
            if (fifo_rd_en) issued    <= issued + LEN_W'(1);
            if (pop)        delivered <= delivered + LEN_W'(1);
         end
         // tail = head + occ; a capture only happens with occ <= 1
         if (inflight) buf_mem[head ^ occ[0]] <= fifo_dout;
         if (pop) head <= ~head;
         case ({inflight, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst)     xfer_cnt <= '0;
      else if (pop) xfer_cnt <= xfer_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, transaction-level reference model, directed and random bursts.
module tb_fifo_stream_reader;
   localparam int DW   = 8;
   localparam int LW   = 8;
   localparam int MASK = 1023;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          m_ready = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy, done, fifo_empty, fifo_rd_en, m_valid;
   logic [DW-1:0] m_data;
   logic [DW-1:0] fifo_dout = '0;
`ifdef FIFO_RD_CNT_EN
   logic [15:0]   xfer_cnt;
`endif

   logic [DW-1:0] mem [0:1023];
   int wr_ptr = 0, rd_ptr = 0, cyc = 0;
   int total = 0, bad = 0;

   fifo_stream_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef FIFO_RD_CNT_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FIFO with one-cycle read latency
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         fifo_dout <= mem[rd_ptr & MASK];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: burst in terms of reads issued, words landed, words transferred
   bit            armed = 0, active = 0, mdone = 0, hold_v = 0;
   int            mlen = 0, reads = 0, xfers = 0, landed = 0, pend = 0, exp_idx = 0;
   int            acc_edge = 0, done_cnt = 0, xcnt = 0;
   logic [DW-1:0] hold_d = '0;
   int            tr_cyc[$], rd_cyc[$], done_cyc[$];
   logic [DW-1:0] tr_data[$];

   always @(negedge clk) begin
      bit ev, ep, er;
      if (armed) begin
         ev = (landed > xfers);
         ep = ev && m_ready;
         er = rst && active && !fifo_empty && (reads < mlen) &&
              ((reads - xfers - (ep ? 1 : 0)) < 2);
         cmp("busy",    32'(busy),       32'(active || mdone));
         cmp("done",    32'(done),       32'(mdone));
         cmp("m_valid", 32'(m_valid),    32'(ev));
         cmp("rd_en",   32'(fifo_rd_en), 32'(er));
         if (ep) begin
            cmp("data", 32'(m_data), 32'(mem[exp_idx & MASK]));
            tr_cyc.push_back(cyc);
            tr_data.push_back(m_data);
         end
         if (hold_v) cmp("hold", 32'(m_data), 32'(hold_d));
`ifdef FIFO_RD_CNT_EN
         cmp("xfer_cnt", 32'(xfer_cnt), 32'(xcnt & 16'hFFFF));
`endif
         if (fifo_rd_en) rd_cyc.push_back(cyc);
         if (done) begin
            done_cyc.push_back(cyc);
            done_cnt++;
         end
         hold_v = ev && !m_ready;
         hold_d = m_data;
         if (ep) begin
            xfers++;
            exp_idx++;
            xcnt++;
         end
         landed += pend;
         pend    = er ? 1 : 0;
         reads  += pend;
         if (mdone) mdone = 0;
         else if (active) begin
            if (ep && xfers == mlen) begin
               active = 0;
               mdone  = 1;
            end
         end else if (start) begin
            acc_edge = cyc + 1;
            if (len == '0) mdone = 1;
            else begin
               active = 1;
               mlen   = int'(len);
               reads  = 0; xfers = 0; landed = 0; pend = 0;
            end
         end
      end
      if (!rst) begin
         armed = 1; active = 0; mdone = 0; hold_v = 0;
         reads = 0; xfers = 0; landed = 0; pend = 0; xcnt = 0;
         exp_idx = rd_ptr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      mem[wr_ptr & MASK] = d;
      wr_ptr++;
   endtask

   task automatic start_burst(input int n);
      len   = LW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      tr_cyc.delete(); tr_data.delete(); rd_cyc.delete(); done_cyc.delete();
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      if (done_cnt == d0) begin
         total++; bad++;
         $display("FAIL %s: no done within %0d cycles", nm, budget);
      end
   endtask

   task automatic wait_tr(input int n, input int budget);
      for (int i = 0; i < budget && tr_data.size() < n; i++) tick();
      if (tr_data.size() < n) begin
         total++; bad++;
         $display("FAIL wait_tr: got %0d transfers expected %0d", tr_data.size(), n);
      end
   endtask

   initial begin
      int e0, pushed;
      logic [DW-1:0] head_exp;
      logic [DW-1:0] bp_words [6];

      // reset held with start high
      rst = 1'b0; start = 1'b1; len = 8'd5; m_ready = 1'b1;
      tick(); tick();
      cmp("rst_busy",  32'(busy),       32'd0);
      cmp("rst_done",  32'(done),       32'd0);
      cmp("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      cmp("rst_valid", 32'(m_valid),    32'd0);
      cmp("rst_data",  32'(m_data),     32'd0);
      start = 1'b0; rst = 1'b1;
      tick();
      cmp("idle_busy", 32'(busy), 32'd0);

      // basic burst
      clear_logs();
      for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
      m_ready = 1'b1;
      start_burst(4);
      e0 = acc_edge;
      wait_done("basic", 50);
      cmp("bb_ntr", 32'(tr_data.size()), 32'd4);
      cmp("bb_nrd", 32'(rd_cyc.size()),  32'd4);
      for (int i = 0; i < 4; i++) begin
         cmp("bb_data",   32'(tr_data[i]), 32'h11 + 32'(i));
         cmp("bb_tr_cyc", 32'(tr_cyc[i]),  32'(e0 + 2 + i));
         cmp("bb_rd_cyc", 32'(rd_cyc[i]),  32'(e0 + i));
      end
      cmp("bb_done_cyc", 32'(done_cyc[0]), 32'(e0 + 6));

      // backpressure mid-burst
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         bp_words[i] = 8'($urandom);
         push(bp_words[i]);
      end
      start_burst(6);
      wait_tr(2, 50);
      m_ready = 1'b0;
      repeat (5) tick();
      m_ready = 1'b1;
      wait_done("bp", 50);
      cmp("bp_ntr", 32'(tr_data.size()), 32'd6);
      for (int i = 0; i < 6; i++) cmp("bp_data", 32'(tr_data[i]), 32'(bp_words[i]));

      // empty stall
      clear_logs();
      push(8'hA0); push(8'hA1);
      start_burst(4);
      repeat (10) tick();
      push(8'hA2); push(8'hA3);
      wait_done("stall", 50);
      cmp("st_ndone", 32'(done_cyc.size()), 32'd1);
      cmp("st_ntr",   32'(tr_data.size()),  32'd4);
      for (int i = 0; i < 4; i++) cmp("st_data", 32'(tr_data[i]), 32'hA0 + 32'(i));

      // zero length
      clear_logs();
      start_burst(0);
      e0 = acc_edge;
      wait_done("zero", 10);
      cmp("zl_done_cyc", 32'(done_cyc[0]),  32'(e0));
      cmp("zl_nrd",      32'(rd_cyc.size()), 32'd0);

      // start during an active burst is ignored
      clear_logs();
      push(8'h31); push(8'h32); push(8'h33);
      m_ready = 1'b0;
      start_burst(3);
      tick();
      start_burst(7);
      m_ready = 1'b1;
      wait_done("ign", 50);
      cmp("ig_ntr", 32'(tr_data.size()), 32'd3);
      cmp("ig_nrd", 32'(rd_cyc.size()),  32'd3);
      cmp("ig_last", 32'(tr_data[2]),    32'h33);

      // reset after two of five words delivered
      clear_logs();
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      start_burst(5);
      wait_tr(2, 50);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      cmp("mr_valid", 32'(m_valid),    32'd0);
      cmp("mr_busy",  32'(busy),       32'd0);
      cmp("mr_rd_en", 32'(fifo_rd_en), 32'd0);
      head_exp = mem[rd_ptr & MASK];
      cmp("mr_head", 32'(head_exp), 32'h54);
      clear_logs();
      start_burst(1);
      wait_done("mr", 20);
      cmp("mr_ntr",  32'(tr_data.size()), 32'd1);
      cmp("mr_data", 32'(tr_data[0]),     32'h54);

      // randomized bursts
      for (int b = 0; b < 40; b++) begin
         int l = $urandom_range(0, 12);
         int d0 = done_cnt;
         pushed = 0;
         m_ready = 1'($urandom_range(0, 1));
         start_burst(l);
         for (int i = 0; i < 500 && done_cnt == d0; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (pushed < l && $urandom_range(0, 1) == 1) begin
               push(8'($urandom));
               pushed++;
            end
            if ($urandom_range(0, 15) == 0) begin
               len   = 8'($urandom);
               start = 1'b1;
            end
            tick();
            start = 1'b0;
         end
         if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL rand_burst %0d: no done (len %0d)", b, l);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
